// File: rtl/fetch_hazard_ctrl.sv
// ============================================================================
// Module      : fetch_hazard_ctrl
// Description : Fetch-stage sequencer: boot hold, load-use interlock,
//               taken-branch redirect and ECALL/EBREAK halt/resume.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int BOOT_CYCLES = 2,
    parameter int LOAD_LAT    = 1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic                  rs1_used_d,
    input  logic                  rs2_used_d,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  mem_rd_e,
    input  logic                  br_taken_e,
    input  logic                  halt_d,
    input  logic                  resume,
    output logic                  stall,
    output logic                  flush_f,
    output logic                  flush_d,
    output logic                  pc_r,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int C_BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int C_LU_W      = (LOAD_LAT > 2) ? $clog2(LOAD_LAT - 1) : 1;
    localparam int C_LU_INIT_I = (LOAD_LAT >= 2) ? (LOAD_LAT - 2) : 0;
    localparam logic [C_BOOT_W-1:0] C_BOOT_INIT = C_BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [C_LU_W-1:0]   C_LU_INIT   = C_LU_W'(C_LU_INIT_I);

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_RUN      = 2'd1,
        S_LU_STALL = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [C_BOOT_W-1:0]   r_boot_cnt;
    logic [C_BOOT_W-1:0]   w_boot_cnt_nxt;
    logic [C_LU_W-1:0]     r_lu_cnt;
    logic [C_LU_W-1:0]     w_lu_cnt_nxt;
    logic                  w_hazard;

    // Register index 0 is hardwired zero, so a load targeting it never interlocks.
    assign w_hazard = mem_rd_e && (rd_e != '0) &&
                      ((rs1_used_d && (rs1_d == rd_e)) ||
                       (rs2_used_d && (rs2_d == rd_e)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_boot_cnt <= C_BOOT_INIT;
            r_lu_cnt   <= '0;
            stall_cnt  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_boot_cnt <= w_boot_cnt_nxt;
            r_lu_cnt   <= w_lu_cnt_nxt;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        stall          = 1'b0;
        flush_f        = 1'b0;
        flush_d        = 1'b0;
        pc_r           = 1'b0;
        halted         = 1'b0;
        w_next_state   = r_state;
        w_boot_cnt_nxt = r_boot_cnt;
        w_lu_cnt_nxt   = r_lu_cnt;

        if (rst) begin
            flush_f = 1'b1;
            flush_d = 1'b1;
        end else begin
            case (r_state)
                S_BOOT: begin
                    flush_f = 1'b1;
                    flush_d = 1'b1;
                    if (r_boot_cnt == '0) begin
                        w_next_state = S_RUN;
                    end else begin
                        w_boot_cnt_nxt = r_boot_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    // Branch outranks hazard/halt: the decode instruction is wrong-path.
                    if (br_taken_e) begin
                        pc_r    = 1'b1;
                        flush_f = 1'b1;
                        flush_d = 1'b1;
                    end else if (w_hazard) begin
                        stall   = 1'b1;
                        flush_d = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_next_state = S_LU_STALL;
                            w_lu_cnt_nxt = C_LU_INIT;
                        end
                    end else if (halt_d) begin
                        stall        = 1'b1;
                        flush_d      = 1'b1;
                        w_next_state = S_HALT;
                    end
                end
                S_LU_STALL: begin
                    if (br_taken_e) begin
                        pc_r         = 1'b1;
                        flush_f      = 1'b1;
                        flush_d      = 1'b1;
                        w_next_state = S_RUN;
                        w_lu_cnt_nxt = '0;
                    end else begin
                        stall   = 1'b1;
                        flush_d = 1'b1;
                        if (r_lu_cnt == '0) begin
                            w_next_state = S_RUN;
                        end else begin
                            w_lu_cnt_nxt = r_lu_cnt - 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    stall   = 1'b1;
                    flush_d = 1'b1;
                    halted  = 1'b1;
                    if (resume) begin
                        w_next_state = S_RUN;
                    end
                end
                default: begin
                    w_next_state = S_BOOT;
                end
            endcase
        end
    end

    a_pc_r_no_stall: assert property (@(posedge clk) disable iff (rst) pc_r |-> !stall);

endmodule

`default_nettype wire

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed bench for fetch_hazard_ctrl: three instances (LOAD_LAT 1/3/4, CNT_W 16/16/3) share stimulus.
`default_nettype none

module tb_fetch_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rd_e;
    logic       rs1_used_d, rs2_used_d, mem_rd_e, br_taken_e, halt_d, resume;

    logic        a_stall, a_flush_f, a_flush_d, a_pc_r, a_halted;
    logic        b_stall, b_flush_f, b_flush_d, b_pc_r, b_halted;
    logic        c_stall, c_flush_f, c_flush_d, c_pc_r, c_halted;
    logic [15:0] a_cnt, b_cnt;
    logic [2:0]  c_cnt;

    // Output vectors ordered {stall, flush_f, flush_d, pc_r, halted}
    wire [4:0] a_out = {a_stall, a_flush_f, a_flush_d, a_pc_r, a_halted};
    wire [4:0] b_out = {b_stall, b_flush_f, b_flush_d, b_pc_r, b_halted};
    wire [4:0] c_out = {c_stall, c_flush_f, c_flush_d, c_pc_r, c_halted};

    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_BOOT = 5'b01100;
    localparam logic [4:0] O_BR   = 5'b01110;
    localparam logic [4:0] O_STL  = 5'b10100;
    localparam logic [4:0] O_HLT  = 5'b10101;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_hazard_ctrl #(.REG_ADDR_W(5), .BOOT_CYCLES(2), .LOAD_LAT(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d),
        .rs2_used_d(rs2_used_d), .rd_e(rd_e), .mem_rd_e(mem_rd_e), .br_taken_e(br_taken_e),
        .halt_d(halt_d), .resume(resume), .stall(a_stall), .flush_f(a_flush_f),
        .flush_d(a_flush_d), .pc_r(a_pc_r), .halted(a_halted), .stall_cnt(a_cnt));

    fetch_hazard_ctrl #(.REG_ADDR_W(5), .BOOT_CYCLES(2), .LOAD_LAT(3), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d),
        .rs2_used_d(rs2_used_d), .rd_e(rd_e), .mem_rd_e(mem_rd_e), .br_taken_e(br_taken_e),
        .halt_d(halt_d), .resume(resume), .stall(b_stall), .flush_f(b_flush_f),
        .flush_d(b_flush_d), .pc_r(b_pc_r), .halted(b_halted), .stall_cnt(b_cnt));

    fetch_hazard_ctrl #(.REG_ADDR_W(5), .BOOT_CYCLES(2), .LOAD_LAT(4), .CNT_W(3)) u_c (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d),
        .rs2_used_d(rs2_used_d), .rd_e(rd_e), .mem_rd_e(mem_rd_e), .br_taken_e(br_taken_e),
        .halt_d(halt_d), .resume(resume), .stall(c_stall), .flush_f(c_flush_f),
        .flush_d(c_flush_d), .pc_r(c_pc_r), .halted(c_halted), .stall_cnt(c_cnt));

    task automatic clr_inputs();
        rs1_d = '0; rs2_d = '0; rd_e = '0;
        rs1_used_d = 1'b0; rs2_used_d = 1'b0; mem_rd_e = 1'b0;
        br_taken_e = 1'b0; halt_d = 1'b0; resume = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves all instances in their first RUN cycle.
    task automatic do_reset();
        clr_inputs();
        rst = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b0;
        repeat (2) next_cycle();
    endtask

    task automatic test_reset();
        clr_inputs();
        br_taken_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (a_out !== O_BOOT) begin n_fail++; $display("FAIL reset_hold cyc%0d got=%b exp=%b", i, a_out, O_BOOT); end
            next_cycle();
        end
        rst    = 1'b0;
        halt_d = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (a_out !== O_BOOT) begin n_fail++; $display("FAIL boot_hold cyc%0d got=%b exp=%b", i, a_out, O_BOOT); end
            next_cycle();
        end
        clr_inputs();
        @(negedge clk);
        n_cmp++;
        if (a_out !== O_IDLE) begin n_fail++; $display("FAIL boot_exit got=%b exp=%b", a_out, O_IDLE); end
        n_cmp++;
        if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL boot_cnt got=%0d exp=0", a_cnt); end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        mem_rd_e = 1'b1; rd_e = 5'd5; rs1_used_d = 1'b1; rs1_d = 5'd5;
        @(negedge clk);
        n_cmp++;
        if (a_out !== O_STL) begin n_fail++; $display("FAIL lu1_stall got=%b exp=%b", a_out, O_STL); end
        next_cycle();
        clr_inputs();
        @(negedge clk);
        n_cmp++;
        if (a_out !== O_IDLE) begin n_fail++; $display("FAIL lu1_release got=%b exp=%b", a_out, O_IDLE); end
        n_cmp++;
        if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL lu1_cnt got=%0d exp=1", a_cnt); end
        next_cycle();
    endtask

    task automatic test_no_hazard_and_lat3();
        do_reset();
        mem_rd_e = 1'b1; rd_e = 5'd0; rs1_used_d = 1'b1; rs1_d = 5'd0;
        @(negedge clk);
        n_cmp++;
        if ({a_out, b_out} !== {O_IDLE, O_IDLE}) begin n_fail++; $display("FAIL rd_zero got=%b_%b exp=0", a_out, b_out); end
        next_cycle();
        rd_e = 5'd9; rs1_d = 5'd9; rs1_used_d = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (a_out !== O_IDLE) begin n_fail++; $display("FAIL rs1_unused got=%b exp=%b", a_out, O_IDLE); end
        next_cycle();
        clr_inputs();
        mem_rd_e = 1'b1; rd_e = 5'd7; rs2_used_d = 1'b1; rs2_d = 5'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (b_out !== O_STL) begin n_fail++; $display("FAIL lu3_stall cyc%0d got=%b exp=%b", i, b_out, O_STL); end
            next_cycle();
            clr_inputs();
        end
        @(negedge clk);
        n_cmp++;
        if (b_out !== O_IDLE) begin n_fail++; $display("FAIL lu3_release got=%b exp=%b", b_out, O_IDLE); end
        n_cmp++;
        if (b_cnt !== 16'd3) begin n_fail++; $display("FAIL lu3_cnt got=%0d exp=3", b_cnt); end
        next_cycle();
    endtask

    task automatic test_branch();
        do_reset();
        br_taken_e = 1'b1; halt_d = 1'b1;
        mem_rd_e = 1'b1; rd_e = 5'd5; rs1_used_d = 1'b1; rs1_d = 5'd5;
        @(negedge clk);
        n_cmp++;
        if ({a_out, b_out} !== {O_BR, O_BR}) begin n_fail++; $display("FAIL br_wins got=%b_%b exp=%b", a_out, b_out, O_BR); end
        next_cycle();
        clr_inputs();
        @(negedge clk);
        n_cmp++;
        if ({a_out, b_out} !== {O_IDLE, O_IDLE}) begin n_fail++; $display("FAIL br_run_next got=%b_%b exp=0", a_out, b_out); end
        next_cycle();
        mem_rd_e = 1'b1; rd_e = 5'd3; rs2_used_d = 1'b1; rs2_d = 5'd3;
        next_cycle();
        clr_inputs();
        br_taken_e = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b_out !== O_BR) begin n_fail++; $display("FAIL br_in_lu got=%b exp=%b", b_out, O_BR); end
        next_cycle();
        clr_inputs();
        @(negedge clk);
        n_cmp++;
        if (b_out !== O_IDLE) begin n_fail++; $display("FAIL br_lu_exit got=%b exp=%b", b_out, O_IDLE); end
        next_cycle();
    endtask

    task automatic test_halt_and_saturation();
        do_reset();
        halt_d = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_out, c_out} !== {O_STL, O_STL}) begin n_fail++; $display("FAIL halt_enter got=%b_%b exp=%b", a_out, c_out, O_STL); end
        next_cycle();
        clr_inputs();
        for (int cyc = 2; cyc <= 10; cyc++) begin
            br_taken_e = (cyc == 3);
            resume     = (cyc == 10);
            @(negedge clk);
            n_cmp++;
            if (a_out !== O_HLT) begin n_fail++; $display("FAIL halted cyc%0d got=%b exp=%b", cyc, a_out, O_HLT); end
            next_cycle();
        end
        clr_inputs();
        @(negedge clk);
        n_cmp++;
        if (a_out !== O_IDLE) begin n_fail++; $display("FAIL resumed got=%b exp=%b", a_out, O_IDLE); end
        n_cmp++;
        if (a_cnt !== 16'd10) begin n_fail++; $display("FAIL halt_cnt got=%0d exp=10", a_cnt); end
        n_cmp++;
        if (c_cnt !== 3'd7) begin n_fail++; $display("FAIL cnt_saturate got=%0d exp=7", c_cnt); end
        next_cycle();
    endtask

    task automatic test_hazard_then_halt();
        do_reset();
        halt_d = 1'b1; mem_rd_e = 1'b1; rd_e = 5'd4; rs1_used_d = 1'b1; rs1_d = 5'd4;
        @(negedge clk);
        n_cmp++;
        if (a_out !== O_STL) begin n_fail++; $display("FAIL hz_halt_c1 got=%b exp=%b", a_out, O_STL); end
        next_cycle();
        clr_inputs();
        halt_d = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a_out !== O_STL) begin n_fail++; $display("FAIL hz_halt_c2 got=%b exp=%b", a_out, O_STL); end
        next_cycle();
        clr_inputs();
        resume = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a_out !== O_HLT) begin n_fail++; $display("FAIL hz_halt_c3 got=%b exp=%b", a_out, O_HLT); end
        next_cycle();
        clr_inputs();
        @(negedge clk);
        n_cmp++;
        if (a_out !== O_IDLE) begin n_fail++; $display("FAIL hz_halt_c4 got=%b exp=%b", a_out, O_IDLE); end
        next_cycle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        mem_rd_e = 1'b1; rd_e = 5'd6; rs1_used_d = 1'b1; rs1_d = 5'd6;
        next_cycle();
        clr_inputs();
        @(negedge clk);
        n_cmp++;
        if (c_out !== O_STL) begin n_fail++; $display("FAIL lu4_c2 got=%b exp=%b", c_out, O_STL); end
        n_cmp++;
        if (c_cnt !== 3'd1) begin n_fail++; $display("FAIL lu4_cnt got=%0d exp=1", c_cnt); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (c_out !== O_BOOT) begin n_fail++; $display("FAIL rst_force got=%b exp=%b", c_out, O_BOOT); end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({c_out, c_cnt} !== {O_BOOT, 3'd0}) begin n_fail++; $display("FAIL reboot cyc%0d got=%b/%0d exp=%b/0", i, c_out, c_cnt, O_BOOT); end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if (c_out !== O_IDLE) begin n_fail++; $display("FAIL reboot_run got=%b exp=%b", c_out, O_IDLE); end
        next_cycle();
    endtask

    initial begin
        clr_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_no_hazard_and_lat3();
        test_branch();
        test_halt_and_saturation();
        test_hazard_then_halt();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
